// File: rtl/alu_seq.sv
// Execute-stage ALU: one-cycle logic/arith ops plus iterative shift-add MUL and
// restoring DIVU/REMU behind a valid/ready handshake.
module alu_seq #(
    parameter int WIDTH = 64,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    input  logic [3:0]       ctrl_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o,
    output logic             illegal_o
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_BUSY = 1'b1;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_NOR  = 4'b1100;
    localparam logic [3:0] OP_MUL  = 4'b1000;
    localparam logic [3:0] OP_DIVU = 4'b1001;
    localparam logic [3:0] OP_REMU = 4'b1010;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             illegal_q, illegal_d;

    logic [WIDTH-1:0] mul_acc_nxt;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_trial;
    logic             div_ge;
    logic [WIDTH-1:0] rem_nxt;
    logic [WIDTH-1:0] quo_nxt;
    logic [WIDTH-1:0] fin_res;
    logic [WIDTH:0]   single_res;
    logic             is_iter;

    // Returns {illegal, result} for every non-iterative opcode.
    function automatic logic [WIDTH:0] single_op(input logic [3:0] op,
                                                 input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
        logic signed [WIDTH-1:0] sa;
        logic signed [WIDTH-1:0] sb;
        sa = a;
        sb = b;
        case (op)
            OP_AND:  single_op = {1'b0, a & b};
            OP_OR:   single_op = {1'b0, a | b};
            OP_ADD:  single_op = {1'b0, a + b};
            OP_SUB:  single_op = {1'b0, a - b};
            OP_SLT:  single_op = {1'b0, {(WIDTH-1){1'b0}}, (sa < sb)};
            OP_NOR:  single_op = {1'b0, ~(a | b)};
            default: single_op = {1'b1, {WIDTH{1'b0}}};
        endcase
    endfunction

    always_comb begin
        mul_acc_nxt = acc_q + (b_q[0] ? a_q : {WIDTH{1'b0}});
        // Remainder shifts left taking the next dividend bit; a clear borrow
        // means the divisor fits and the quotient bit is 1.
        div_shift   = {acc_q, a_q[WIDTH-1]};
        div_trial   = div_shift - {1'b0, b_q};
        div_ge      = ~div_trial[WIDTH];
        rem_nxt     = div_ge ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0];
        quo_nxt     = {a_q[WIDTH-2:0], div_ge};
        single_res  = single_op(ctrl_i, src1_i, src2_i);
        is_iter     = (ctrl_i == OP_MUL) || (ctrl_i == OP_DIVU) || (ctrl_i == OP_REMU);
        case (op_q)
            OP_MUL:  fin_res = mul_acc_nxt;
            OP_DIVU: fin_res = quo_nxt;
            default: fin_res = rem_nxt;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        acc_d     = acc_q;
        valid_d   = 1'b0;
        result_d  = result_q;
        zero_d    = zero_q;
        illegal_d = illegal_q;
        if (state_q == S_IDLE) begin
            if (valid_i) begin
                if (is_iter) begin
                    state_d = S_BUSY;
                    op_d    = ctrl_i;
                    a_d     = src1_i;
                    b_d     = src2_i;
                    acc_d   = {WIDTH{1'b0}};
                    cnt_d   = {CNT_W{1'b0}};
                end else begin
                    valid_d   = 1'b1;
                    result_d  = single_res[WIDTH-1:0];
                    zero_d    = (single_res[WIDTH-1:0] == {WIDTH{1'b0}});
                    illegal_d = single_res[WIDTH];
                end
            end
        end else begin
            cnt_d = cnt_q + 1'b1;
            if (op_q == OP_MUL) begin
                acc_d = mul_acc_nxt;
                a_d   = a_q << 1;
                b_d   = b_q >> 1;
            end else begin
                acc_d = rem_nxt;
                a_d   = quo_nxt;
            end
            if (cnt_q == CNT_LAST) begin
                state_d   = S_IDLE;
                cnt_d     = {CNT_W{1'b0}};
                valid_d   = 1'b1;
                result_d  = fin_res;
                zero_d    = (fin_res == {WIDTH{1'b0}});
                illegal_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            cnt_q     <= {CNT_W{1'b0}};
            valid_q   <= 1'b0;
            result_q  <= {WIDTH{1'b0}};
            zero_q    <= 1'b1;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            valid_q   <= valid_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            illegal_q <= illegal_d;
        end
    end

    // Datapath registers carry no reset; they are always reloaded on accept.
    always_ff @(posedge clk_i) begin
        op_q  <= op_d;
        a_q   <= a_d;
        b_q   <= b_d;
        acc_q <= acc_d;
    end

    assign ready_o   = (state_q == S_IDLE);
    assign valid_o   = valid_q;
    assign result_o  = result_q;
    assign zero_o    = zero_q;
    assign illegal_o = illegal_q;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: a 64-bit and an 8-bit instance checked against an
// arithmetic reference model with directed and random stimulus.
module tb_alu_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic        v_i = 1'b0;
    logic        rdy;
    logic [63:0] s1 = '0;
    logic [63:0] s2 = '0;
    logic [3:0]  ctl = '0;
    logic        v_o;
    logic [63:0] res;
    logic        zr;
    logic        ill;

    logic        v8_i = 1'b0;
    logic        rdy8;
    logic [7:0]  a8 = '0;
    logic [7:0]  b8 = '0;
    logic [3:0]  ctl8 = '0;
    logic        v8_o;
    logic [7:0]  res8;
    logic        zr8;
    logic        ill8;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(64)) dut64 (
        .clk_i(clk), .rst_i(rst), .valid_i(v_i), .ready_o(rdy),
        .src1_i(s1), .src2_i(s2), .ctrl_i(ctl),
        .valid_o(v_o), .result_o(res), .zero_o(zr), .illegal_o(ill)
    );

    alu_seq #(.WIDTH(8)) dut8 (
        .clk_i(clk), .rst_i(rst), .valid_i(v8_i), .ready_o(rdy8),
        .src1_i(a8), .src2_i(b8), .ctrl_i(ctl8),
        .valid_o(v8_o), .result_o(res8), .zero_o(zr8), .illegal_o(ill8)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: {illegal, result} for one-cycle ops.
    function automatic logic [64:0] ref_single(input logic [3:0] op, input logic [63:0] a,
                                               input logic [63:0] b);
        longint sa;
        longint sb;
        sa = a;
        sb = b;
        case (op)
            4'd0:    return {1'b0, a & b};
            4'd1:    return {1'b0, a | b};
            4'd2:    return {1'b0, 64'(a + b)};
            4'd6:    return {1'b0, 64'(a - b)};
            4'd7:    return {1'b0, (sa < sb) ? 64'd1 : 64'd0};
            4'd12:   return {1'b0, ~(a | b)};
            default: return {1'b1, 64'd0};
        endcase
    endfunction

    function automatic logic [63:0] ref_iter64(input logic [3:0] op, input logic [63:0] a,
                                               input logic [63:0] b);
        if (op == 4'd8) return 64'(a * b);
        if (op == 4'd9) return (b == 0) ? {64{1'b1}} : a / b;
        return (b == 0) ? a : a % b;
    endfunction

    function automatic logic [7:0] ref_iter8(input logic [3:0] op, input logic [7:0] a,
                                             input logic [7:0] b);
        if (op == 4'd8) return 8'(a * b);
        if (op == 4'd9) return (b == 0) ? 8'hFF : a / b;
        return (b == 0) ? a : a % b;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tests_run += 5;
        if (rdy !== 1'b1) begin tests_failed++; $display("FAIL reset_ready got %b want 1", rdy); end
        if (v_o !== 1'b0) begin tests_failed++; $display("FAIL reset_valid got %b want 0", v_o); end
        if (res !== 64'd0) begin tests_failed++; $display("FAIL reset_result got %h want 0", res); end
        if (zr !== 1'b1) begin tests_failed++; $display("FAIL reset_zero got %b want 1", zr); end
        if (ill !== 1'b0) begin tests_failed++; $display("FAIL reset_illegal got %b want 0", ill); end
    endtask

    task automatic test_directed_single();
        v_i = 1'b1; ctl = 4'd2; s1 = 64'd5; s2 = 64'd7;
        tick();
        tests_run += 3;
        if (v_o !== 1'b1) begin tests_failed++; $display("FAIL add_valid got %b want 1", v_o); end
        if (res !== 64'd12) begin tests_failed++; $display("FAIL add_result got %h want c", res); end
        if (zr !== 1'b0) begin tests_failed++; $display("FAIL add_zero got %b want 0", zr); end
        ctl = 4'd6; s1 = 64'd3; s2 = 64'd3;
        tick();
        tests_run += 3;
        if (v_o !== 1'b1) begin tests_failed++; $display("FAIL sub_valid got %b want 1", v_o); end
        if (res !== 64'd0) begin tests_failed++; $display("FAIL sub_result got %h want 0", res); end
        if (zr !== 1'b1) begin tests_failed++; $display("FAIL sub_zero got %b want 1", zr); end
        ctl = 4'd7; s1 = {64{1'b1}}; s2 = 64'd1;
        tick();
        tests_run++;
        if (res !== 64'd1) begin tests_failed++; $display("FAIL slt_neg got %h want 1", res); end
        s1 = 64'd1; s2 = {64{1'b1}};
        tick();
        tests_run++;
        if (res !== 64'd0) begin tests_failed++; $display("FAIL slt_swap got %h want 0", res); end
        ctl = 4'd12; s1 = 64'd0; s2 = 64'd0;
        tick();
        tests_run++;
        if (res !== {64{1'b1}}) begin tests_failed++; $display("FAIL nor_zero got %h want all-ones", res); end
        ctl = 4'd3; s1 = 64'd77; s2 = 64'd11;
        tick();
        tests_run += 4;
        if (v_o !== 1'b1) begin tests_failed++; $display("FAIL illegal_valid got %b want 1", v_o); end
        if (ill !== 1'b1) begin tests_failed++; $display("FAIL illegal_flag got %b want 1", ill); end
        if (res !== 64'd0) begin tests_failed++; $display("FAIL illegal_result got %h want 0", res); end
        if (zr !== 1'b1) begin tests_failed++; $display("FAIL illegal_zero got %b want 1", zr); end
        v_i = 1'b0;
        tick();
        tests_run += 2;
        if (v_o !== 1'b0) begin tests_failed++; $display("FAIL valid_drop got %b want 0", v_o); end
        if (ill !== 1'b1) begin tests_failed++; $display("FAIL illegal_hold got %b want 1", ill); end
    endtask

    task automatic test_back_to_back();
        logic [3:0]  ops [13] = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd12, 4'd3,
                                  4'd4, 4'd5, 4'd11, 4'd13, 4'd14, 4'd15};
        logic [64:0] exp;
        for (int i = 0; i < 40; i++) begin
            v_i = 1'b1;
            ctl = ops[$urandom_range(0, 12)];
            s1 = {$urandom, $urandom};
            s2 = (i % 5 == 0) ? s1 : {$urandom, $urandom};
            exp = ref_single(ctl, s1, s2);
            tick();
            tests_run += 4;
            if (v_o !== 1'b1) begin tests_failed++; $display("FAIL b2b_valid[%0d] got %b want 1", i, v_o); end
            if (res !== exp[63:0]) begin tests_failed++; $display("FAIL b2b_result[%0d] op %h got %h want %h", i, ctl, res, exp[63:0]); end
            if (zr !== (exp[63:0] == 64'd0)) begin tests_failed++; $display("FAIL b2b_zero[%0d] got %b want %b", i, zr, exp[63:0] == 64'd0); end
            if (ill !== exp[64]) begin tests_failed++; $display("FAIL b2b_illegal[%0d] got %b want %b", i, ill, exp[64]); end
        end
        v_i = 1'b0;
        tick();
    endtask

    task automatic test_iterative();
        logic [3:0]  op_t [16];
        logic [63:0] a_t [16];
        logic [63:0] b_t [16];
        logic [63:0] exp;
        int lat;
        int low;
        op_t[0] = 4'd8; a_t[0] = 64'h1_0000_0001; b_t[0] = 64'd3;
        op_t[1] = 4'd9; a_t[1] = 64'd100; b_t[1] = 64'd7;
        op_t[2] = 4'd10; a_t[2] = 64'd100; b_t[2] = 64'd7;
        op_t[3] = 4'd9; a_t[3] = {$urandom, $urandom}; b_t[3] = 64'd0;
        op_t[4] = 4'd10; a_t[4] = 64'd9; b_t[4] = 64'd0;
        op_t[5] = 4'd9; a_t[5] = 64'd3; b_t[5] = 64'd100;
        for (int i = 6; i < 16; i++) begin
            op_t[i] = 4'd8 + 4'($urandom_range(0, 2));
            a_t[i] = {$urandom, $urandom};
            b_t[i] = {$urandom, $urandom} >> $urandom_range(0, 63);
        end
        for (int i = 0; i < 16; i++) begin
            exp = ref_iter64(op_t[i], a_t[i], b_t[i]);
            v_i = 1'b1; ctl = op_t[i]; s1 = a_t[i]; s2 = b_t[i];
            tick();
            // Inputs scrambled and request held while busy: must be ignored.
            s1 = ~s1; s2 = ~s2; ctl = 4'd2;
            low = (rdy === 1'b0) ? 1 : 0;
            lat = 0;
            while (v_o !== 1'b1 && lat < 200) begin
                tick();
                lat++;
                if (rdy === 1'b0) low++;
            end
            v_i = 1'b0;
            tests_run += 5;
            if (lat !== 64) begin tests_failed++; $display("FAIL iter_latency[%0d] got %0d want 64", i, lat); end
            if (low !== 64) begin tests_failed++; $display("FAIL iter_busy[%0d] got %0d want 64", i, low); end
            if (res !== exp) begin tests_failed++; $display("FAIL iter_result[%0d] op %h got %h want %h", i, op_t[i], res, exp); end
            if (zr !== (exp == 64'd0)) begin tests_failed++; $display("FAIL iter_zero[%0d] got %b want %b", i, zr, exp == 64'd0); end
            if (ill !== 1'b0) begin tests_failed++; $display("FAIL iter_illegal[%0d] got %b want 0", i, ill); end
            tick();
            tests_run += 2;
            if (v_o !== 1'b0) begin tests_failed++; $display("FAIL iter_single_pulse[%0d] got %b want 0", i, v_o); end
            if (rdy !== 1'b1) begin tests_failed++; $display("FAIL iter_no_reaccept[%0d] got %b want 1", i, rdy); end
        end
    endtask

    task automatic test_reset_abort();
        int seen;
        v_i = 1'b1; ctl = 4'd9; s1 = 64'd1000; s2 = 64'd3;
        tick();
        v_i = 1'b0;
        repeat (9) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests_run += 4;
        if (v_o !== 1'b0) begin tests_failed++; $display("FAIL abort_valid got %b want 0", v_o); end
        if (rdy !== 1'b1) begin tests_failed++; $display("FAIL abort_ready got %b want 1", rdy); end
        if (res !== 64'd0) begin tests_failed++; $display("FAIL abort_result got %h want 0", res); end
        if (zr !== 1'b1) begin tests_failed++; $display("FAIL abort_zero got %b want 1", zr); end
        seen = 0;
        for (int i = 0; i < 70; i++) begin
            tick();
            if (v_o === 1'b1) seen++;
        end
        tests_run++;
        if (seen !== 0) begin tests_failed++; $display("FAIL abort_late_valid got %0d want 0", seen); end
        v_i = 1'b1; ctl = 4'd2; s1 = 64'd2; s2 = 64'd3;
        tick();
        v_i = 1'b0;
        tests_run += 2;
        if (v_o !== 1'b1) begin tests_failed++; $display("FAIL post_abort_valid got %b want 1", v_o); end
        if (res !== 64'd5) begin tests_failed++; $display("FAIL post_abort_result got %h want 5", res); end
        rst = 1'b1; v_i = 1'b1; ctl = 4'd2; s1 = 64'd5; s2 = 64'd7;
        tick();
        rst = 1'b0; v_i = 1'b0;
        tests_run += 2;
        if (v_o !== 1'b0) begin tests_failed++; $display("FAIL rst_wins_valid got %b want 0", v_o); end
        if (res !== 64'd0) begin tests_failed++; $display("FAIL rst_wins_result got %h want 0", res); end
        tick();
    endtask

    task automatic test_width8();
        logic [3:0] op_t [10];
        logic [7:0] a_t [10];
        logic [7:0] b_t [10];
        logic [7:0] exp;
        int lat;
        op_t[0] = 4'd8; a_t[0] = 8'd15; b_t[0] = 8'd17;
        op_t[1] = 4'd9; a_t[1] = 8'd200; b_t[1] = 8'd7;
        op_t[2] = 4'd10; a_t[2] = 8'd200; b_t[2] = 8'd7;
        op_t[3] = 4'd9; a_t[3] = 8'd5; b_t[3] = 8'd0;
        for (int i = 4; i < 10; i++) begin
            op_t[i] = 4'd8 + 4'($urandom_range(0, 2));
            a_t[i] = 8'($urandom);
            b_t[i] = 8'($urandom) >> $urandom_range(0, 7);
        end
        for (int i = 0; i < 10; i++) begin
            exp = ref_iter8(op_t[i], a_t[i], b_t[i]);
            v8_i = 1'b1; ctl8 = op_t[i]; a8 = a_t[i]; b8 = b_t[i];
            tick();
            lat = 0;
            while (v8_o !== 1'b1 && lat < 50) begin
                tick();
                lat++;
            end
            v8_i = 1'b0;
            tests_run += 4;
            if (lat !== 8) begin tests_failed++; $display("FAIL w8_latency[%0d] got %0d want 8", i, lat); end
            if (res8 !== exp) begin tests_failed++; $display("FAIL w8_result[%0d] op %h got %h want %h", i, op_t[i], res8, exp); end
            if (zr8 !== (exp == 8'd0)) begin tests_failed++; $display("FAIL w8_zero[%0d] got %b want %b", i, zr8, exp == 8'd0); end
            if (rdy8 !== 1'b1) begin tests_failed++; $display("FAIL w8_ready[%0d] got %b want 1", i, rdy8); end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_directed_single();
        test_back_to_back();
        test_iterative();
        test_reset_abort();
        test_width8();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
